// File: rtl/mem_access.sv
// Memory-access stage of the 5-stage RISC-V pipeline.
// Issues loads and stores to data memory over a req/ack handshake, formats
// load data, builds store strobes, and stalls upstream while a request is
// outstanding. Non-memory instructions pass straight through in one cycle.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] result_i,
  input  logic [4:0]  rd_i,
  input  logic        wb_en_i,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_o,
  output logic        wb_en_o,
  output logic [4:0]  rd_o,
  output logic [31:0] result_o,
  output logic        misalign_o,
  output logic        err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A zero TIMEOUT disables the abort entirely.
  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  count_reg;

  // Transaction context captured at accept time.
  logic [4:0]  rd_reg;
  logic        wb_reg;
  logic [2:0]  size_reg;
  logic [1:0]  lane_reg;

  // Decode of the incoming op.
  logic        op_read;
  logic        op_write;
  logic        op_none;
  logic        op_illegal;
  logic        op_mem;
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        misaligned;
  logic        accept;

  // Handshake events while BUSY.
  logic        ack_hit;
  logic        timeout_hit;

  // Request payload built from the incoming op.
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;

  // Load formatting.
  logic [7:0]  rdata_byte [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;

  // Classify the incoming op: kind, access size and alignment.
  always_comb begin
    op_read    = mem_op_i[4];
    op_write   = mem_op_i[3];
    op_none    = !op_read && !op_write;
    op_illegal = op_read && op_write;
    op_mem     = op_read ^ op_write;
    // Size codes 011, 110 and 111 fall through to word.
    size_byte  = (mem_op_i[1:0] == 2'b00);
    size_half  = (mem_op_i[1:0] == 2'b01);
    size_word  = !size_byte && !size_half;
    misaligned = op_mem && ((size_half && addr_i[0]) ||
                            (size_word && (addr_i[1:0] != 2'b00)));
    accept     = valid_i && op_mem && !misaligned;
  end

  // Per-lane store strobe and data: bytes replicate to every lane,
  // halfwords to both halves, words pass straight through.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
      assign strb_next[gi] = op_write &&
                             (size_word ||
                              (size_half && (addr_i[1] == gi[1])) ||
                              (size_byte && (addr_i[1:0] == gi[1:0])));
      assign wdata_next[8*gi +: 8] = size_byte ? wdata_i[7:0] :
                                     size_half ? wdata_i[8*(gi%2) +: 8] :
                                                 wdata_i[8*gi +: 8];
    end
  endgenerate

  // Split read data into byte lanes for the load aligner.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
      assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  // Align the returned word to the latched lane and sign/zero-extend.
  always_comb begin
    byte_val  = rdata_byte[lane_reg];
    half_val  = lane_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (size_reg[1:0])
      2'b00:   load_data = {{24{!size_reg[2] && byte_val[7]}}, byte_val};
      2'b01:   load_data = {{16{!size_reg[2] && half_val[15]}}, half_val};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state logic and the combinational stall back to upstream.
  always_comb begin
    state_next  = state_reg;
    stall_o     = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          stall_o    = 1'b1;
        end
      end
      BUSY: begin
        // Ack only counts while a request is actually on the bus;
        // when ack and timeout coincide the ack wins.
        ack_hit     = dmem_ack && dmem_req;
        timeout_hit = TO_EN && !ack_hit && (count_reg == TO_LAST);
        if (ack_hit || timeout_hit) begin
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Cycles spent BUSY without an ack; cleared whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) begin
      count_reg <= 8'd0;
    end else if (TO_EN && !ack_hit) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // Memory request side: launch on accept, hold until ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wstrb <= 4'd0;
      dmem_wdata <= 32'd0;
      rd_reg     <= 5'd0;
      wb_reg     <= 1'b0;
      size_reg   <= 3'd0;
      lane_reg   <= 2'd0;
    end else if (state_reg == IDLE && accept) begin
      dmem_req   <= 1'b1;
      dmem_we    <= op_write;
      dmem_addr  <= {addr_i[31:2], 2'b00};
      dmem_wstrb <= strb_next;
      dmem_wdata <= wdata_next;
      rd_reg     <= rd_i;
      wb_reg     <= wb_en_i;
      size_reg   <= mem_op_i[2:0];
      lane_reg   <= addr_i[1:0];
    end else if (state_reg == BUSY && (ack_hit || timeout_hit)) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wstrb <= 4'd0;
    end
  end

  // Writeback payload to memwbreg; every field is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      wb_en_o    <= 1'b0;
      rd_o       <= 5'd0;
      result_o   <= 32'd0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      wb_en_o    <= 1'b0;
      rd_o       <= 5'd0;
      result_o   <= 32'd0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      if (state_reg == IDLE && valid_i) begin
        if (op_none) begin
          valid_o  <= 1'b1;
          wb_en_o  <= wb_en_i;
          rd_o     <= rd_i;
          result_o <= result_i;
        end else if (op_illegal) begin
          valid_o <= 1'b1;
          rd_o    <= rd_i;
          err_o   <= 1'b1;
        end else if (misaligned) begin
          valid_o    <= 1'b1;
          rd_o       <= rd_i;
          misalign_o <= 1'b1;
        end
      end else if (state_reg == BUSY && ack_hit) begin
        valid_o <= 1'b1;
        rd_o    <= rd_reg;
        // Stores complete with no writeback and a zero result.
        if (!dmem_we) begin
          wb_en_o  <= wb_reg;
          result_o <= load_data;
        end
      end else if (state_reg == BUSY && timeout_hit) begin
        valid_o <= 1'b1;
        rd_o    <= rd_reg;
        err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access. Two instances share stimulus: one with
// TIMEOUT=4 for the main and timeout checks, one with TIMEOUT=0 for the
// long-latency check.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] result_i;
  logic [4:0]  rd_i;
  logic        wb_en_i;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        stall_o, dmem_req, dmem_we, valid_o, wb_en_o, misalign_o, err_o;
  logic [31:0] dmem_addr, dmem_wdata, result_o;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  rd_o;

  logic        z_stall_o, z_dmem_req, z_dmem_we, z_valid_o, z_wb_en_o, z_misalign_o, z_err_o;
  logic [31:0] z_dmem_addr, z_dmem_wdata, z_result_o;
  logic [3:0]  z_dmem_wstrb;
  logic [4:0]  z_rd_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .result_i(result_i), .rd_i(rd_i),
    .wb_en_i(wb_en_i), .stall_o(stall_o), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .valid_o(valid_o), .wb_en_o(wb_en_o), .rd_o(rd_o), .result_o(result_o),
    .misalign_o(misalign_o), .err_o(err_o)
  );

  mem_access #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .result_i(result_i), .rd_i(rd_i),
    .wb_en_i(wb_en_i), .stall_o(z_stall_o), .dmem_req(z_dmem_req),
    .dmem_we(z_dmem_we), .dmem_addr(z_dmem_addr), .dmem_wstrb(z_dmem_wstrb),
    .dmem_wdata(z_dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .valid_o(z_valid_o), .wb_en_o(z_wb_en_o), .rd_o(z_rd_o), .result_o(z_result_o),
    .misalign_o(z_misalign_o), .err_o(z_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_i  = 1'b0;
    mem_op_i = 5'd0;
    addr_i   = 32'd0;
    wdata_i  = 32'd0;
    result_i = 32'd0;
    rd_i     = 5'd0;
    wb_en_i  = 1'b0;
  endtask

  // Full load/store transaction: accept, ack_delay plain BUSY cycles, ack.
  // Returns one cycle after the ack with inputs idle.
  task automatic mem_txn(input string tag, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int ack_delay,
                         input logic [31:0] rdata, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_result,
                         input logic exp_wb);
    valid_i = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = wdata;
    rd_i = rd; wb_en_i = 1'b1; result_i = 32'h5555_AAAA;
    #1;
    check_eq({tag, "_accept_stall"}, 32'(stall_o), 32'd1);
    check_eq({tag, "_accept_noreq"}, 32'(dmem_req), 32'd0);
    step();
    check_eq({tag, "_req"}, 32'(dmem_req), 32'd1);
    check_eq({tag, "_we"}, 32'(dmem_we), 32'(op[3]));
    check_eq({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    check_eq({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
    check_eq({tag, "_wdata"}, dmem_wdata, exp_wdata);
    check_eq({tag, "_busy_valid"}, 32'(valid_o), 32'd0);
    for (int i = 0; i < ack_delay; i++) begin
      check_eq({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
      step();
      check_eq({tag, "_wait_req"}, 32'(dmem_req), 32'd1);
    end
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    #1;
    check_eq({tag, "_ack_stall"}, 32'(stall_o), 32'd0);
    check_eq({tag, "_ack_strb_held"}, 32'(dmem_wstrb), 32'(exp_strb));
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    idle_in();
    #1;
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_eq({tag, "_wb_en"}, 32'(wb_en_o), 32'(exp_wb));
    check_eq({tag, "_result"}, result_o, exp_result);
    check_eq({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    if (exp_wb) check_eq({tag, "_rd"}, 32'(rd_o), 32'(rd));
    $display("[TB] txn %s op=%b addr=0x%08h result=0x%08h", tag, op, addr, result_o);
  endtask

  // Op that must be rejected without a request (misaligned or illegal).
  task automatic reject_txn(input string tag, input logic [4:0] op, input logic [31:0] addr,
                            input logic exp_mis, input logic exp_err);
    valid_i = 1'b1; mem_op_i = op; addr_i = addr; rd_i = 5'd4; wb_en_i = 1'b1;
    #1;
    check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
    step();
    idle_in();
    #1;
    check_eq({tag, "_noreq"}, 32'(dmem_req), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_eq({tag, "_wb_en"}, 32'(wb_en_o), 32'd0);
    check_eq({tag, "_misalign"}, 32'(misalign_o), 32'(exp_mis));
    check_eq({tag, "_err"}, 32'(err_o), 32'(exp_err));
    step();
    check_eq({tag, "_pulse_end"}, 32'(misalign_o | err_o | valid_o), 32'd0);
    $display("[TB] txn %s op=%b addr=0x%08h rejected", tag, op, addr);
  endtask

  initial begin
    int held;
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    idle_in();
    repeat (3) step();
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_err", 32'(err_o | misalign_o), 32'd0);
    rst = 1'b0;
    step();

    // Non-memory pass-through.
    valid_i = 1'b1; mem_op_i = 5'b00000; result_i = 32'h0000_1234; rd_i = 5'd5; wb_en_i = 1'b1;
    #1;
    check_eq("alu_stall", 32'(stall_o), 32'd0);
    step();
    idle_in();
    #1;
    check_eq("alu_valid", 32'(valid_o), 32'd1);
    check_eq("alu_result", result_o, 32'h0000_1234);
    check_eq("alu_rd", 32'(rd_o), 32'd5);
    check_eq("alu_wb_en", 32'(wb_en_o), 32'd1);
    check_eq("alu_req", 32'(dmem_req), 32'd0);
    $display("[TB] txn alu result=0x%08h", result_o);
    step();
    check_eq("alu_valid_drop", 32'(valid_o), 32'd0);

    // Loads and stores.
    mem_txn("lb",  5'b10000, 32'h0000_0103, 32'd0, 5'd6, 2, 32'h80FF_1234, 4'b0000, 32'd0, 32'hFFFF_FF80, 1'b1);
    mem_txn("lbu", 5'b10100, 32'h0000_0103, 32'd0, 5'd6, 2, 32'h80FF_1234, 4'b0000, 32'd0, 32'h0000_0080, 1'b1);
    mem_txn("sh",  5'b01001, 32'h0000_0202, 32'h0000_ABCD, 5'd1, 0, 32'd0, 4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0);
    mem_txn("lhu", 5'b10101, 32'h0000_0202, 32'd0, 5'd8, 0, 32'hBEEF_0000, 4'b0000, 32'd0, 32'h0000_BEEF, 1'b1);
    mem_txn("sb",  5'b01000, 32'h0000_0301, 32'h0000_005A, 5'd1, 1, 32'd0, 4'b0010, 32'h5A5A_5A5A, 32'd0, 1'b0);
    mem_txn("sw",  5'b01010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd1, 1, 32'd0, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0);
    mem_txn("lh_hi", 5'b10001, 32'h0000_0302, 32'd0, 5'd10, 0, 32'h8001_7FFF, 4'b0000, 32'd0, 32'hFFFF_8001, 1'b1);
    mem_txn("lh_lo", 5'b10001, 32'h0000_0300, 32'd0, 5'd11, 0, 32'h8001_7FFF, 4'b0000, 32'd0, 32'h0000_7FFF, 1'b1);
    mem_txn("lw_s3", 5'b10011, 32'h0000_0104, 32'd0, 5'd12, 1, 32'h1357_9BDF, 4'b0000, 32'd0, 32'h1357_9BDF, 1'b1);

    // Rejected ops.
    reject_txn("lw_mis",  5'b10010, 32'h0000_0105, 1'b1, 1'b0);
    reject_txn("lh_mis",  5'b10001, 32'h0000_0101, 1'b1, 1'b0);
    reject_txn("s3_mis",  5'b10011, 32'h0000_0102, 1'b1, 1'b0);
    reject_txn("illegal", 5'b11010, 32'h0000_0100, 1'b0, 1'b1);

    // Timeout with TIMEOUT=4: request high for exactly 4 cycles.
    valid_i = 1'b1; mem_op_i = 5'b10010; addr_i = 32'h0000_0040; rd_i = 5'd3; wb_en_i = 1'b1;
    #1;
    check_eq("to_accept_stall", 32'(stall_o), 32'd1);
    step();
    for (int k = 1; k <= 4; k++) begin
      check_eq("to_req", 32'(dmem_req), 32'd1);
      check_eq("to_stall", 32'(stall_o), (k == 4) ? 32'd0 : 32'd1);
      step();
    end
    idle_in();
    #1;
    check_eq("to_req_drop", 32'(dmem_req), 32'd0);
    check_eq("to_valid", 32'(valid_o), 32'd1);
    check_eq("to_err", 32'(err_o), 32'd1);
    check_eq("to_wb_en", 32'(wb_en_o), 32'd0);
    check_eq("to_idle_stall", 32'(stall_o), 32'd0);
    $display("[TB] txn timeout err=%0b", err_o);
    step();
    check_eq("to_err_pulse", 32'(err_o), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // TIMEOUT=0: a 300-cycle wait still completes.
    valid_i = 1'b1; mem_op_i = 5'b10010; addr_i = 32'h0000_0080; rd_i = 5'd9; wb_en_i = 1'b1;
    #1;
    check_eq("t0_accept_stall", 32'(z_stall_o), 32'd1);
    step();
    held = 0;
    for (int i = 0; i < 300; i++) begin
      if (z_dmem_req && z_stall_o) held++;
      step();
    end
    check_eq("t0_held_cycles", 32'(held), 32'd300);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("t0_ack_stall", 32'(z_stall_o), 32'd0);
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    idle_in();
    #1;
    check_eq("t0_valid", 32'(z_valid_o), 32'd1);
    check_eq("t0_result", z_result_o, 32'hCAFE_F00D);
    check_eq("t0_err", 32'(z_err_o), 32'd0);
    check_eq("t0_rd", 32'(z_rd_o), 32'd9);
    $display("[TB] txn timeout0 result=0x%08h", z_result_o);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Reset in the 2nd BUSY cycle, then a late ack.
    valid_i = 1'b1; mem_op_i = 5'b10010; addr_i = 32'h0000_0044; rd_i = 5'd7; wb_en_i = 1'b1;
    #1;
    check_eq("mr_accept_stall", 32'(stall_o), 32'd1);
    step();
    check_eq("mr_busy1_req", 32'(dmem_req), 32'd1);
    step();
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    check_eq("mr_req_drop", 32'(dmem_req), 32'd0);
    check_eq("mr_valid", 32'(valid_o), 32'd0);
    check_eq("mr_stall", 32'(stall_o), 32'd0);
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    #1;
    check_eq("mr_late_ack_valid", 32'(valid_o), 32'd0);
    check_eq("mr_late_ack_req", 32'(dmem_req), 32'd0);
    $display("[TB] txn reset_mid_busy req=%0b valid=%0b", dmem_req, valid_o);
    mem_txn("lw_after_rst", 5'b10010, 32'h0000_0048, 32'd0, 5'd7, 1, 32'h1234_5678, 4'b0000, 32'd0, 32'h1234_5678, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
